// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard/stall controller: register index type,
// SRAM-wait FSM states and the RAW-match helper used for the EXE and MEM compares.
package pipeline_hazard_ctrl_pkg;

    localparam int REG_IDX_W = 4;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd2
    } mem_state_e;

    // r0 is an ordinary ARM register, so a zero index is compared like any other.
    function automatic logic raw_match(input logic     wb_en,
                                       input reg_idx_t dest,
                                       input reg_idx_t src1,
                                       input reg_idx_t src2,
                                       input logic     two_src);
        return wb_en && ((src1 == dest) || (two_src && (src2 == dest)));
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle between the pipeline stages and the hazard controller: operand/destination
// information in, per-stage freeze/flush/bubble controls and the SRAM error flag out.
interface pipeline_hazard_ctrl_if;
    import pipeline_hazard_ctrl_pkg::*;

    logic     id_valid;
    reg_idx_t src1;
    reg_idx_t src2;
    logic     two_src;
    logic     exe_wb_en;
    reg_idx_t exe_dest;
    logic     exe_mem_read;
    logic     mem_wb_en;
    reg_idx_t mem_dest;
    logic     branch_taken;
    logic     mem_req;
    logic     mem_ready;

    logic     hazard;
    logic     freeze_pc;
    logic     flush;
    logic     freeze_all;
    logic     mem_error;

    modport master (
        output id_valid, src1, src2, two_src,
        output exe_wb_en, exe_dest, exe_mem_read,
        output mem_wb_en, mem_dest,
        output branch_taken, mem_req, mem_ready,
        input  hazard, freeze_pc, flush, freeze_all, mem_error
    );

    modport slave (
        input  id_valid, src1, src2, two_src,
        input  exe_wb_en, exe_dest, exe_mem_read,
        input  mem_wb_en, mem_dest,
        input  branch_taken, mem_req, mem_ready,
        output hazard, freeze_pc, flush, freeze_all, mem_error
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Event counter that sticks at its all-ones value instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline: RAW detection against EXE/MEM,
// branch flush, and whole-pipeline freeze while the data SRAM is busy.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter bit FWD_EN      = 1'b0,
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    pipeline_hazard_ctrl_if.slave hz,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     flush_cnt
);

    localparam int                WAIT_W    = $clog2(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    mem_state_e        state;
    mem_state_e        state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_cnt_nxt;
    logic              mem_error_q;
    logic              set_error;

    logic raw_exe;
    logic raw_mem;
    logic raw;
    logic freeze_all_c;
    logic flush_c;
    logic hazard_c;
    logic freeze_pc_c;

    always_comb begin
        raw_exe = raw_match(hz.exe_wb_en, hz.exe_dest, hz.src1, hz.src2, hz.two_src);
        raw_mem = raw_match(hz.mem_wb_en, hz.mem_dest, hz.src1, hz.src2, hz.two_src);
        // With forwarding only a load in EXE cannot supply its result in time.
        raw     = FWD_EN ? (raw_exe && hz.exe_mem_read) : (raw_exe || raw_mem);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            wait_cnt    <= '0;
            mem_error_q <= 1'b0;
        end else begin
            state       <= state_nxt;
            wait_cnt    <= wait_cnt_nxt;
            mem_error_q <= mem_error_q | set_error;
        end
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        set_error    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (hz.mem_req && !hz.mem_ready) begin
                    state_nxt    = ST_MEM_WAIT;
                    wait_cnt_nxt = '0;
                end
            end
            ST_MEM_WAIT: begin
                if (hz.mem_ready) begin
                    state_nxt = ST_IDLE;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_nxt = ST_ERROR;
                    set_error = 1'b1;
                end else begin
                    wait_cnt_nxt = wait_cnt + 1'b1;
                end
            end
            ST_ERROR: begin
                state_nxt = ST_ERROR;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Freeze starts in the request cycle itself; reset forces every control low at once.
    always_comb begin
        freeze_all_c = rst && (((state == ST_IDLE) && hz.mem_req && !hz.mem_ready) ||
                               (state == ST_MEM_WAIT) || (state == ST_ERROR));
        flush_c      = rst && hz.branch_taken && !freeze_all_c;
        hazard_c     = rst && hz.id_valid && raw && !flush_c && !freeze_all_c;
        freeze_pc_c  = hazard_c || freeze_all_c;
    end

    assign hz.hazard     = hazard_c;
    assign hz.flush      = flush_c;
    assign hz.freeze_all = freeze_all_c;
    assign hz.freeze_pc  = freeze_pc_c;
    assign hz.mem_error  = mem_error_q;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (freeze_pc_c),
        .q   (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (flush_c),
        .q   (flush_cnt)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: two configurations (no forwarding / short timeout /
// 2-bit counters, and forwarding / default timeout / 16-bit counters) driven in lockstep.
module tb_pipeline_hazard_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic       id_valid, two_src, exe_wb_en, exe_mem_read, mem_wb_en;
    logic       branch_taken, mem_req, mem_ready;
    logic [3:0] src1, src2, exe_dest, mem_dest;

    pipeline_hazard_ctrl_if ifa ();
    pipeline_hazard_ctrl_if ifb ();

    assign ifa.id_valid = id_valid;          assign ifb.id_valid = id_valid;
    assign ifa.src1 = src1;                  assign ifb.src1 = src1;
    assign ifa.src2 = src2;                  assign ifb.src2 = src2;
    assign ifa.two_src = two_src;            assign ifb.two_src = two_src;
    assign ifa.exe_wb_en = exe_wb_en;        assign ifb.exe_wb_en = exe_wb_en;
    assign ifa.exe_dest = exe_dest;          assign ifb.exe_dest = exe_dest;
    assign ifa.exe_mem_read = exe_mem_read;  assign ifb.exe_mem_read = exe_mem_read;
    assign ifa.mem_wb_en = mem_wb_en;        assign ifb.mem_wb_en = mem_wb_en;
    assign ifa.mem_dest = mem_dest;          assign ifb.mem_dest = mem_dest;
    assign ifa.branch_taken = branch_taken;  assign ifb.branch_taken = branch_taken;
    assign ifa.mem_req = mem_req;            assign ifb.mem_req = mem_req;
    assign ifa.mem_ready = mem_ready;        assign ifb.mem_ready = mem_ready;

    logic [1:0]  stall_a, flush_a;
    logic [15:0] stall_b, flush_b;

    pipeline_hazard_ctrl #(.FWD_EN(1'b0), .MEM_TIMEOUT(4), .CNT_W(2)) dut_a (
        .clk(clk), .rst(rst), .hz(ifa), .stall_cnt(stall_a), .flush_cnt(flush_a));

    pipeline_hazard_ctrl #(.FWD_EN(1'b1), .MEM_TIMEOUT(64), .CNT_W(16)) dut_b (
        .clk(clk), .rst(rst), .hz(ifb), .stall_cnt(stall_b), .flush_cnt(flush_b));

    logic        o_hz [2], o_fl [2], o_fp [2], o_fa [2], o_err [2];
    logic [31:0] o_stall [2], o_flush [2];
    assign o_hz[0] = ifa.hazard;      assign o_hz[1] = ifb.hazard;
    assign o_fl[0] = ifa.flush;       assign o_fl[1] = ifb.flush;
    assign o_fp[0] = ifa.freeze_pc;   assign o_fp[1] = ifb.freeze_pc;
    assign o_fa[0] = ifa.freeze_all;  assign o_fa[1] = ifb.freeze_all;
    assign o_err[0] = ifa.mem_error;  assign o_err[1] = ifb.mem_error;
    assign o_stall[0] = {30'd0, stall_a};  assign o_stall[1] = {16'd0, stall_b};
    assign o_flush[0] = {30'd0, flush_a};  assign o_flush[1] = {16'd0, flush_b};

    // Reference model: each configuration's knobs plus its abstract memory-port status.
    bit fwd_m  [2] = '{1'b0, 1'b1};
    int tmo_m  [2] = '{4, 64};
    int cmax_m [2] = '{3, 65535};

    bit m_busy  [2];
    bit m_err   [2];
    int m_waited[2];
    int m_stall [2];
    int m_flush [2];

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_busy[d] = 0; m_err[d] = 0; m_waited[d] = 0;
            m_stall[d] = 0; m_flush[d] = 0;
        end
    endtask

    task automatic model_eval(input int d, output bit fa, output bit fl, output bit hz);
        logic [3:0] reads [$];
        bit hit_exe, hit_mem, raw;
        reads.push_back(src1);
        if (two_src) reads.push_back(src2);
        hit_exe = 0;
        hit_mem = 0;
        foreach (reads[i]) begin
            if (exe_wb_en && reads[i] == exe_dest) hit_exe = 1;
            if (mem_wb_en && reads[i] == mem_dest) hit_mem = 1;
        end
        raw = fwd_m[d] ? (hit_exe && exe_mem_read) : (hit_exe || hit_mem);
        fa  = rst && (m_err[d] || m_busy[d] || (mem_req && !mem_ready));
        fl  = rst && branch_taken && !fa;
        hz  = rst && id_valid && raw && !fl && !fa;
    endtask

    task automatic check_all(input string tag);
        bit fa, fl, hz;
        for (int d = 0; d < 2; d++) begin
            string n;
            n = $sformatf("%s.%s", tag, (d == 0) ? "A" : "B");
            model_eval(d, fa, fl, hz);
            chk({n, ".hazard"},     {31'd0, o_hz[d]},  {31'd0, hz});
            chk({n, ".flush"},      {31'd0, o_fl[d]},  {31'd0, fl});
            chk({n, ".freeze_pc"},  {31'd0, o_fp[d]},  {31'd0, hz || fa});
            chk({n, ".freeze_all"}, {31'd0, o_fa[d]},  {31'd0, fa});
            chk({n, ".mem_error"},  {31'd0, o_err[d]}, {31'd0, m_err[d]});
            chk({n, ".stall_cnt"},  o_stall[d], 32'(m_stall[d]));
            chk({n, ".flush_cnt"},  o_flush[d], 32'(m_flush[d]));
        end
    endtask

    task automatic model_clock();
        bit fa, fl, hz;
        for (int d = 0; d < 2; d++) begin
            model_eval(d, fa, fl, hz);
            if ((hz || fa) && m_stall[d] < cmax_m[d]) m_stall[d]++;
            if (fl && m_flush[d] < cmax_m[d]) m_flush[d]++;
            if (m_err[d]) begin
                m_err[d] = 1;
            end else if (m_busy[d]) begin
                if (mem_ready) m_busy[d] = 0;
                else if (m_waited[d] == tmo_m[d] - 1) begin m_err[d] = 1; m_busy[d] = 0; end
                else m_waited[d]++;
            end else if (mem_req && !mem_ready) begin
                m_busy[d] = 1;
                m_waited[d] = 0;
            end
        end
    endtask

    // Called at posedge+3 with inputs settled; leaves time at the next posedge+1.
    task automatic step(input string tag);
        check_all(tag);
        model_clock();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_valid = 0; two_src = 0; exe_wb_en = 0; exe_mem_read = 0; mem_wb_en = 0;
        branch_taken = 0; mem_req = 0; mem_ready = 0;
        src1 = 0; src2 = 0; exe_dest = 0; mem_dest = 0;
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b0;
        model_reset();
        #1;
        check_all(tag);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        clear_inputs();
        model_reset();
        mem_req = 1; branch_taken = 1; id_valid = 1; exe_wb_en = 1;
        repeat (2) @(posedge clk);
        #3;
        check_all("reset");
        clear_inputs();
        #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // Plain RAW on src1 from EXE.
        id_valid = 1; src1 = 3; exe_wb_en = 1; exe_dest = 3; #2;
        chk("t1.A.hazard_const", {31'd0, ifa.hazard}, 32'd1);
        chk("t1.B.hazard_const", {31'd0, ifb.hazard}, 32'd0);
        step("t1");
        exe_mem_read = 1; #2;
        chk("t2.B.loaduse_const", {31'd0, ifb.hazard}, 32'd1);
        step("t2_load");
        exe_wb_en = 0; exe_mem_read = 0; mem_wb_en = 1; mem_dest = 3; #2;
        step("t2_mem_only");

        // src2 only counts when two_src is set; r0 is a real register.
        mem_wb_en = 0; src1 = 1; src2 = 5; exe_dest = 5; exe_wb_en = 1; exe_mem_read = 1;
        two_src = 0; #2; step("t3_one_src");
        two_src = 1; #2; step("t3_two_src");
        two_src = 0; src1 = 0; exe_dest = 0; #2; step("t3_r0");

        // Branch beats hazard.
        do_reset("t4_rst");
        src1 = 3; exe_dest = 3; exe_wb_en = 1; exe_mem_read = 1; id_valid = 1;
        branch_taken = 1; #2;
        chk("t4.A.flush_const",  {31'd0, ifa.flush},  32'd1);
        chk("t4.B.hazard_const", {31'd0, ifb.hazard}, 32'd0);
        step("t4_branch");
        clear_inputs(); #2;
        chk("t4.B.flush_cnt_const", o_flush[1], 32'd1);
        step("t4_after");

        // SRAM busy three cycles, ready in the fourth; branch masked while frozen.
        do_reset("t5_rst");
        mem_req = 1; mem_ready = 0; #2; step("t5_req");
        mem_req = 0; branch_taken = 1; #2;
        chk("t5.B.flush_masked", {31'd0, ifb.flush}, 32'd0);
        step("t5_wait1");
        branch_taken = 0; #2; step("t5_wait2");
        mem_ready = 1; #2;
        chk("t5.B.freeze_ready_cycle", {31'd0, ifb.freeze_all}, 32'd1);
        step("t5_ready");
        mem_ready = 0; #2;
        chk("t5.B.stall_cnt_const", o_stall[1], 32'd4);
        chk("t5.A.stall_sat_const", o_stall[0], 32'd3);
        step("t5_release");

        // Timeout into ERROR on the short-timeout instance, then async reset mid-wait.
        do_reset("t6_rst");
        mem_req = 1; #2; step("t6_req");
        mem_req = 0;
        for (int i = 0; i < 6; i++) begin #2; step("t6_wait"); end
        #2;
        chk("t6.A.mem_error_const", {31'd0, ifa.mem_error}, 32'd1);
        chk("t6.A.freeze_stuck",    {31'd0, ifa.freeze_all}, 32'd1);
        step("t6_error");
        #2;
        do_reset("t6_async");

        // Randomized traffic with periodic resets.
        for (int c = 0; c < 400; c++) begin
            id_valid     = ($urandom_range(3) != 0);
            src1         = 4'($urandom_range(3));
            src2         = 4'($urandom_range(3));
            two_src      = $urandom_range(1) != 0;
            exe_wb_en    = $urandom_range(1) != 0;
            exe_dest     = 4'($urandom_range(3));
            exe_mem_read = $urandom_range(1) != 0;
            mem_wb_en    = $urandom_range(1) != 0;
            mem_dest     = 4'($urandom_range(3));
            branch_taken = ($urandom_range(4) == 0);
            mem_req      = ($urandom_range(3) == 0);
            mem_ready    = ($urandom_range(2) == 0);
            #2;
            step("rand");
            if (c % 60 == 59) do_reset("rand_rst");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
